hdmi_island_scheduler: RTL and testbench

Sequences the HDMI data-island period in horizontal blanking and arbitrates its packet slots between four sources: audio clock regeneration (ACR), audio sample packets, AVI infoframe and audio infoframe. It buffers incoming stereo samples and issues per-slot packet type and start strobes to the TERC4 packet engine. It also issues preamble and guard-band controls for the island and for the video leading edge to the TMDS output mux.

---
 rtl/hdmi_pkg.sv | 28 ++
 rtl/audio_sample_fifo.sv | 45 ++++
 rtl/hdmi_island_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_hdmi_island_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared 720x480p timing, island lengths, packet-type and island FSM encodings
package hdmi_pkg;
    localparam int DEF_H_ACTIVE     = 720;
    localparam int DEF_H_TOTAL      = 858;
    localparam int DEF_V_ACTIVE     = 480;
    localparam int DEF_V_TOTAL      = 525;
    localparam int DEF_ISLAND_START = 724;
    localparam int DEF_PRE_LEN      = 8;
    localparam int DEF_GB_LEN       = 2;
    localparam int DEF_PKT_LEN      = 32;
    localparam int DEF_MAX_PKTS     = 2;
    localparam int DEF_ACR_EVERY    = 32;
    localparam int DEF_FIFO_DEPTH   = 8;
    typedef enum logic [2:0] {
        PKT_NONE = 3'd0,
        PKT_ACR  = 3'd1,
        PKT_AUD  = 3'd2,
        PKT_AVI  = 3'd3,
        PKT_AIF  = 3'd4
    } pkt_type_e;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_LGB,
        ST_PKT,
        ST_TGB
    } isl_state_e;
endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: {R,L} sample buffer, one push and a pop of up to four entries per cycle
//   i_clk/i_rst_n : clock, async active-low reset
//   i_push/i_data : write one 32-bit sample (caller qualifies with o_ready)
//   i_pop_n       : number of entries to drop this cycle (never more than o_count)
//   o_count       : occupancy, o_ready = not full
//   o_peek        : the four oldest entries, oldest in [31:0]
module audio_sample_fifo
    import hdmi_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [31:0]              i_data,
    input  logic [2:0]               i_pop_n,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_ready,
    output logic [127:0]             o_peek
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    always_ff @(posedge i_clk)
        if (i_push) r_mem[r_wr] <= i_data;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + AW'(i_push);
            r_rd    <= r_rd + AW'(i_pop_n);
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop_n);
        end
    always_comb begin
        o_peek = '0;
        for (int i = 0; i < 4; i++)
            o_peek[32*i +: 32] = r_mem[r_rd + AW'(i)];
    end
    assign o_count = r_count;
    assign o_ready = r_count < (AW+1)'(DEPTH);
endmodule

// File: rtl/hdmi_island_scheduler.sv
// hdmi_island_scheduler: data-island sequencing and packet-slot arbitration in horizontal blanking
//   i_pixclk/i_rst_n          : pixel clock, async active-low reset
//   i_counter_x/i_counter_y   : raster position
//   i_smp_valid/l/r, o_smp_ready : stereo sample handshake into the FIFO
//   o_isl_pre/gb/data         : island preamble, guard band, packet body
//   o_pkt_start/o_pkt_type    : slot strobe and slot packet type
//   o_aud_data/o_aud_present  : samples of the latest audio slot and their lane mask
//   o_vid_pre/o_vid_gb        : video leading-edge preamble and guard band
// Every output describes the raster position presented one cycle earlier.
module hdmi_island_scheduler
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int ISLAND_START = DEF_ISLAND_START,
    parameter int PRE_LEN      = DEF_PRE_LEN,
    parameter int GB_LEN       = DEF_GB_LEN,
    parameter int PKT_LEN      = DEF_PKT_LEN,
    parameter int MAX_PKTS     = DEF_MAX_PKTS,
    parameter int ACR_EVERY    = DEF_ACR_EVERY,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic         i_pixclk,
    input  logic         i_rst_n,
    input  logic [9:0]   i_counter_x,
    input  logic [9:0]   i_counter_y,
    input  logic         i_smp_valid,
    input  logic [15:0]  i_smp_l,
    input  logic [15:0]  i_smp_r,
    output logic         o_smp_ready,
    output logic         o_isl_pre,
    output logic         o_isl_gb,
    output logic         o_isl_data,
    output logic         o_pkt_start,
    output logic [2:0]   o_pkt_type,
    output logic [127:0] o_aud_data,
    output logic [3:0]   o_aud_present,
    output logic         o_vid_pre,
    output logic         o_vid_gb
);
    localparam int CW = $clog2(ACR_EVERY);
    localparam int FW = $clog2(FIFO_DEPTH);
    if (ISLAND_START < H_ACTIVE ||
        ISLAND_START + PRE_LEN + 2*GB_LEN + MAX_PKTS*PKT_LEN > H_TOTAL - PRE_LEN - GB_LEN - 4) begin : g_bad_timing
        $error("data island does not fit in horizontal blanking");
    end
    logic [FW:0]   w_count;
    logic          w_ready;
    logic [127:0]  w_peek;
    logic          w_push;
    pkt_type_e     w_sel;
    logic          w_pending;
    logic          w_lgb_end;
    logic          w_pkt_end;
    logic          w_slot_go;
    logic          w_aud_go;
    logic [2:0]    w_n;
    logic [2:0]    w_pop_n;
    logic [3:0]    w_mask;
    logic [127:0]  w_lanes;
    logic          w_frame;
    logic          w_vid_pre;
    logic          w_vid_gb;
    isl_state_e    r_state;
    logic [7:0]    r_cnt;
    logic [2:0]    r_slots;
    logic [CW-1:0] r_smp_cnt;
    logic          r_acr_due;
    logic          r_avi_due;
    logic          r_aif_due;
    logic          r_isl_pre;
    logic          r_isl_gb;
    logic          r_isl_data;
    logic          r_pkt_start;
    pkt_type_e     r_pkt_type;
    logic [127:0]  r_aud_data;
    logic [3:0]    r_aud_present;
    logic          r_vid_pre;
    logic          r_vid_gb;
    assign w_push = i_smp_valid && w_ready;
    audio_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_pixclk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  ({i_smp_r, i_smp_l}),
        .i_pop_n (w_pop_n),
        .o_count (w_count),
        .o_ready (w_ready),
        .o_peek  (w_peek)
    );
    always_comb begin
        w_sel     = r_acr_due ? PKT_ACR : (w_count != '0) ? PKT_AUD : r_avi_due ? PKT_AVI : r_aif_due ? PKT_AIF : PKT_NONE;
        w_pending = w_sel != PKT_NONE;
        w_lgb_end = r_state == ST_LGB && r_cnt == 8'(GB_LEN-1);
        w_pkt_end = r_state == ST_PKT && r_cnt == 8'(PKT_LEN-1);
        // the first slot needs no pending check: the island only opens when something is pending
        w_slot_go = w_lgb_end || (w_pkt_end && r_slots < 3'(MAX_PKTS) && w_pending);
        w_aud_go  = w_slot_go && w_sel == PKT_AUD;
        w_n       = w_count >= (FW+1)'(4) ? 3'd4 : 3'(w_count);
        w_pop_n   = w_aud_go ? w_n : 3'd0;
        w_mask    = '0;
        w_lanes   = '0;
        for (int i = 0; i < 4; i++) begin
            w_mask[i]            = 3'(i) < w_n;
            w_lanes[32*i +: 32]  = w_mask[i] ? w_peek[32*i +: 32] : 32'd0;
        end
        w_frame   = i_counter_x == 10'd0 && i_counter_y == 10'(V_ACTIVE);
        w_vid_pre = i_counter_x >= 10'(H_TOTAL-PRE_LEN-GB_LEN) && i_counter_x < 10'(H_TOTAL-GB_LEN);
        w_vid_gb  = i_counter_x >= 10'(H_TOTAL-GB_LEN) && i_counter_x < 10'(H_TOTAL) &&
                    (i_counter_y + 10'd1 < 10'(V_ACTIVE) || i_counter_y == 10'(V_TOTAL-1));
    end
    always_ff @(posedge i_pixclk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_slots       <= '0;
            r_smp_cnt     <= '0;
            r_acr_due     <= 1'b0;
            r_avi_due     <= 1'b1;
            r_aif_due     <= 1'b1;
            r_isl_pre     <= 1'b0;
            r_isl_gb      <= 1'b0;
            r_isl_data    <= 1'b0;
            r_pkt_start   <= 1'b0;
            r_pkt_type    <= PKT_NONE;
            r_aud_data    <= '0;
            r_aud_present <= '0;
            r_vid_pre     <= 1'b0;
            r_vid_gb      <= 1'b0;
        end else begin
            r_vid_pre   <= w_vid_pre;
            r_vid_gb    <= w_vid_gb;
            r_pkt_start <= w_slot_go;
            if (w_push) r_smp_cnt <= r_smp_cnt + CW'(1);
            // a due flag being set wins over its clear in the same cycle
            r_acr_due <= (w_push && &r_smp_cnt) || (r_acr_due && !(w_slot_go && w_sel == PKT_ACR));
            r_avi_due <= w_frame || (r_avi_due && !(w_slot_go && w_sel == PKT_AVI));
            r_aif_due <= w_frame || (r_aif_due && !(w_slot_go && w_sel == PKT_AIF));
            if (w_slot_go) r_pkt_type <= w_sel;
            if (w_aud_go) begin
                r_aud_data    <= w_lanes;
                r_aud_present <= w_mask;
            end
            case (r_state)
                ST_IDLE:
                    if (i_counter_x == 10'(ISLAND_START) && w_pending) begin
                        r_state   <= ST_PRE;
                        r_cnt     <= '0;
                        r_isl_pre <= 1'b1;
                    end
                ST_PRE:
                    if (r_cnt == 8'(PRE_LEN-1)) begin
                        r_state   <= ST_LGB;
                        r_cnt     <= '0;
                        r_isl_pre <= 1'b0;
                        r_isl_gb  <= 1'b1;
                    end else r_cnt <= r_cnt + 8'd1;
                ST_LGB:
                    if (w_lgb_end) begin
                        r_state    <= ST_PKT;
                        r_cnt      <= '0;
                        r_slots    <= 3'd1;
                        r_isl_gb   <= 1'b0;
                        r_isl_data <= 1'b1;
                    end else r_cnt <= r_cnt + 8'd1;
                ST_PKT:
                    if (w_pkt_end) begin
                        r_cnt <= '0;
                        if (w_slot_go) r_slots <= r_slots + 3'd1;
                        else begin
                            r_state    <= ST_TGB;
                            r_isl_data <= 1'b0;
                            r_isl_gb   <= 1'b1;
                            r_pkt_type <= PKT_NONE;
                        end
                    end else r_cnt <= r_cnt + 8'd1;
                ST_TGB:
                    if (r_cnt == 8'(GB_LEN-1)) begin
                        r_state  <= ST_IDLE;
                        r_cnt    <= '0;
                        r_isl_gb <= 1'b0;
                    end else r_cnt <= r_cnt + 8'd1;
                default: r_state <= ST_IDLE;
            endcase
        end
    assign o_smp_ready   = w_ready;
    assign o_isl_pre     = r_isl_pre;
    assign o_isl_gb      = r_isl_gb;
    assign o_isl_data    = r_isl_data;
    assign o_pkt_start   = r_pkt_start;
    assign o_pkt_type    = r_pkt_type;
    assign o_aud_data    = r_aud_data;
    assign o_aud_present = r_aud_present;
    assign o_vid_pre     = r_vid_pre;
    assign o_vid_gb      = r_vid_gb;
endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// tb_hdmi_island_scheduler: directed raster lines against a slot-level reference model and scoreboard
module tb_hdmi_island_scheduler;
    localparam int XI = 724;
    localparam int XG = 732;
    localparam int XS = 734;
    localparam int PL = 32;
    typedef struct {
        logic [2:0]   typ;
        logic [3:0]   pres;
        logic [127:0] data;
    } exp_t;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [9:0]   cx = '0;
    logic [9:0]   cy = '0;
    logic         valid = 1'b0;
    logic [15:0]  sl = '0;
    logic [15:0]  sr = '0;
    logic         o_smp_ready, o_isl_pre, o_isl_gb, o_isl_data, o_pkt_start, o_vid_pre, o_vid_gb;
    logic [2:0]   o_pkt_type;
    logic [127:0] o_aud_data;
    logic [3:0]   o_aud_present;
    exp_t         sb[$];
    logic [31:0]  mq[$];
    int           n_assert = 0;
    int           n_fail = 0;
    int           m_acr_cnt, m_nslots;
    bit           m_acr, m_avi, m_aif, m_isl, m_start;
    logic [2:0]   m_type;
    logic [3:0]   m_pres;
    logic [127:0] m_data;
    hdmi_island_scheduler dut (
        .i_pixclk      (clk),
        .i_rst_n       (rst_n),
        .i_counter_x   (cx),
        .i_counter_y   (cy),
        .i_smp_valid   (valid),
        .i_smp_l       (sl),
        .i_smp_r       (sr),
        .o_smp_ready   (o_smp_ready),
        .o_isl_pre     (o_isl_pre),
        .o_isl_gb      (o_isl_gb),
        .o_isl_data    (o_isl_data),
        .o_pkt_start   (o_pkt_start),
        .o_pkt_type    (o_pkt_type),
        .o_aud_data    (o_aud_data),
        .o_aud_present (o_aud_present),
        .o_vid_pre     (o_vid_pre),
        .o_vid_gb      (o_vid_gb)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic reset_model();
        mq.delete();
        sb.delete();
        m_acr_cnt = 0;
        m_nslots  = 0;
        m_acr     = 0;
        m_avi     = 1;
        m_aif     = 1;
        m_isl     = 0;
        m_start   = 0;
        m_type    = '0;
        m_pres    = '0;
        m_data    = '0;
    endtask
    task automatic check_reset_outs();
        chk("rst_outs", {o_isl_pre, o_isl_gb, o_isl_data, o_pkt_start, o_pkt_type, o_vid_pre, o_vid_gb, o_aud_present}, '0);
        chk("rst_aud_data", o_aud_data, '0);
        chk("rst_ready", o_smp_ready, 1);
    endtask
    task automatic model_edge(input int x, input int y, input bit v, input logic [31:0] d);
        bit   rdy;
        bit   pend;
        int   n;
        exp_t e;
        rdy     = mq.size() < 8;
        pend    = m_acr || mq.size() > 0 || m_avi || m_aif;
        m_start = 0;
        if (x == 0) m_isl = 0;
        if (x == XI && pend) begin
            m_isl    = 1;
            m_nslots = 0;
        end
        if (m_isl && x == XS + PL*m_nslots && m_nslots < 2 && pend) begin
            m_start = 1;
            m_nslots++;
            if (m_acr) begin
                m_type = 3'd1;
                m_acr  = 0;
            end else if (mq.size() > 0) begin
                m_type = 3'd2;
                n      = mq.size() > 4 ? 4 : mq.size();
                m_pres = '0;
                m_data = '0;
                for (int i = 0; i < n; i++) begin
                    m_pres[i]           = 1'b1;
                    m_data[32*i +: 32]  = mq.pop_front();
                end
            end else if (m_avi) begin
                m_type = 3'd3;
                m_avi  = 0;
            end else begin
                m_type = 3'd4;
                m_aif  = 0;
            end
            e.typ  = m_type;
            e.pres = m_pres;
            e.data = m_data;
            sb.push_back(e);
        end
        if (x == 0 && y == 480) begin
            m_avi = 1;
            m_aif = 1;
        end
        if (v && rdy) begin
            mq.push_back(d);
            m_acr_cnt = (m_acr_cnt + 1) % 32;
            if (m_acr_cnt == 0) m_acr = 1;
        end
    endtask
    task automatic check_out(input int x, input int y);
        bit         pre, gb, dat, vp, vg;
        int         dend;
        logic [2:0] t;
        exp_t       e;
        dend = XS + PL*m_nslots;
        pre  = m_isl && x >= XI && x < XG;
        dat  = m_isl && x >= XS && x < dend;
        gb   = m_isl && ((x >= XG && x < XS) || (x >= dend && x < dend + 2));
        vp   = x >= 848 && x < 856;
        vg   = x >= 856 && x < 858 && (y + 1 < 480 || y == 524);
        t    = dat ? m_type : 3'd0;
        chk("ctl", {o_isl_pre, o_isl_gb, o_isl_data, o_pkt_start, o_pkt_type, o_vid_pre, o_vid_gb},
                   {pre, gb, dat, m_start, t, vp, vg});
        chk("excl", $onehot0({o_isl_pre, o_isl_gb, o_isl_data, o_vid_pre, o_vid_gb}), 1);
        if (o_pkt_start) begin
            if (sb.size() == 0) chk("sb_nonempty_at_start", sb.size(), 1);
            else begin
                e = sb.pop_front();
                chk("slot_type", o_pkt_type, e.typ);
                chk("aud_present", o_aud_present, e.pres);
                chk("aud_data", o_aud_data, e.data);
            end
        end
    endtask
    task automatic cycle(input int x, input int y, input bit v);
        cx    = 10'(x);
        cy    = 10'(y);
        valid = v;
        sl    = 16'($urandom);
        sr    = 16'($urandom);
        chk("smp_ready", o_smp_ready, mq.size() < 8);
        @(posedge clk);
        #1;
        model_edge(x, y, v, {sr, sl});
        check_out(x, y);
    endtask
    task automatic run_line(input int y, input int rst_x, input int plo, input int phi);
        for (int x = 0; x < 858; x++) begin
            if (x == rst_x) begin
                cx    = 10'(x);
                valid = 1'b0;
                rst_n = 1'b0;
                #1;
                check_reset_outs();
                reset_model();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end else cycle(x, y, x >= plo && x <= phi);
        end
        valid = 1'b0;
    endtask
    task automatic push(input int n);
        for (int i = 0; i < n; i++) cycle(100, 12, 1'b1);
        valid = 1'b0;
    endtask
    initial begin
        reset_model();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_line(10, 760, -1, -1);
        run_line(11, -1, -1, -1);
        run_line(12, -1, -1, -1);
        push(5);
        run_line(13, -1, -1, -1);
        push(8);
        run_line(14, -1, -1, -1);
        push(8);
        run_line(15, -1, -1, -1);
        push(8);
        run_line(16, -1, -1, -1);
        push(3);
        run_line(17, -1, -1, -1);
        run_line(480, -1, -1, -1);
        run_line(481, -1, -1, -1);
        run_line(524, -1, -1, -1);
        push(10);
        run_line(0, -1, 733, 735);
        run_line(1, -1, -1, -1);
        chk("sb_drained", sb.size(), 0);
        chk("fifo_model_empty_ready", o_smp_ready, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
